// File: rtl/lsram_fifo_ctrl.sv
// Single-clock FIFO controller driving an external two-port LSRAM.
// Occupancy is held in a count register; pointers wrap naturally and never disambiguate full/empty.
module lsram_fifo_ctrl #(
    parameter int WIDTH     = 32,
    parameter int ADDR_W    = 7,
    parameter int AFULL_TH  = 120,
    parameter int AEMPTY_TH = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_we,
    input  logic [WIDTH-1:0]  i_din,
    input  logic              i_re,
    output logic [WIDTH-1:0]  o_dout,
    output logic              o_dvalid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_afull,
    output logic              o_aempty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic              o_ram_wen,
    output logic [WIDTH-1:0]  o_ram_wdata,
    output logic [ADDR_W-1:0] o_ram_raddr,
    output logic              o_ram_ren,
    input  logic [WIDTH-1:0]  i_ram_rdata
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  C_DEPTH   = CNT_W'(2 ** ADDR_W);
    localparam logic [CNT_W-1:0]  C_AFULL   = CNT_W'(AFULL_TH);
    localparam logic [CNT_W-1:0]  C_AEMPTY  = CNT_W'(AEMPTY_TH);
    localparam logic [CNT_W-1:0]  C_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]  C_CNT_ZERO = CNT_W'(0);
    localparam logic [ADDR_W-1:0] C_PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_PTR_ZERO = ADDR_W'(0);

    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_dvalid;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [CNT_W-1:0]  w_count_next;

    // Accept decisions; reset gates the enables so an access in the reset cycle never reaches the RAM.
    always_comb begin
        w_wr_ok = i_we & ~r_full  & ~i_reset;
        w_rd_ok = i_re & ~r_empty & ~i_reset;
    end

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        w_count_next = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_count_next = r_count + C_CNT_ONE;
            2'b01:   w_count_next = r_count - C_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Pointer, occupancy, flag and strobe registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wptr      <= C_PTR_ZERO;
            r_rptr      <= C_PTR_ZERO;
            r_count     <= C_CNT_ZERO;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_dvalid    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + C_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + C_PTR_ONE;
            end
            r_count     <= w_count_next;
            r_full      <= (w_count_next == C_DEPTH);
            r_empty     <= (w_count_next == C_CNT_ZERO);
            r_afull     <= (w_count_next >= C_AFULL);
            r_aempty    <= (w_count_next <= C_AEMPTY);
            r_dvalid    <= w_rd_ok;
            r_overflow  <= i_we & r_full;
            r_underflow <= i_re & r_empty;
        end
    end

    // RAM-side connections and status outputs.
    always_comb begin
        o_ram_wen   = w_wr_ok;
        o_ram_waddr = r_wptr;
        o_ram_wdata = i_din;
        o_ram_ren   = w_rd_ok;
        o_ram_raddr = r_rptr;
        o_dout      = i_ram_rdata;
        o_dvalid    = r_dvalid;
        o_full      = r_full;
        o_empty     = r_empty;
        o_afull     = r_afull;
        o_aempty    = r_aempty;
        o_count     = r_count;
        o_overflow  = r_overflow;
        o_underflow = r_underflow;
    end

endmodule

// File: tb/tb_lsram_fifo_ctrl.sv
// Directed bench for lsram_fifo_ctrl with a behavioural RAM, a reference FIFO model
// and a scoreboard monitor that checks every DVALID beat against the expected queue.
module tb_lsram_fifo_ctrl;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_we;
    logic [31:0] i_din;
    logic        i_re;
    logic [31:0] o_dout;
    logic        o_dvalid, o_full, o_empty, o_afull, o_aempty;
    logic [7:0]  o_count;
    logic        o_overflow, o_underflow;
    logic [6:0]  o_ram_waddr, o_ram_raddr;
    logic        o_ram_wen, o_ram_ren;
    logic [31:0] o_ram_wdata;
    logic [31:0] ram_rdata;

    logic [31:0] mem [0:127];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          m_count  = 0;
    logic [6:0]  m_wptr   = 7'd0;
    logic [6:0]  m_rptr   = 7'd0;
    logic [31:0] data_q [$];
    logic [31:0] exp_q  [$];
    logic [31:0] pat;

    lsram_fifo_ctrl dut (
        .i_clock(clk), .i_reset(i_reset), .i_we(i_we), .i_din(i_din), .i_re(i_re),
        .o_dout(o_dout), .o_dvalid(o_dvalid), .o_full(o_full), .o_empty(o_empty),
        .o_afull(o_afull), .o_aempty(o_aempty), .o_count(o_count),
        .o_overflow(o_overflow), .o_underflow(o_underflow),
        .o_ram_waddr(o_ram_waddr), .o_ram_wen(o_ram_wen), .o_ram_wdata(o_ram_wdata),
        .o_ram_raddr(o_ram_raddr), .o_ram_ren(o_ram_ren), .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural two-port RAM with 1-cycle read latency.
    always @(posedge clk) begin
        if (o_ram_wen) mem[o_ram_waddr] <= o_ram_wdata;
        if (o_ram_ren) ram_rdata <= mem[o_ram_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; entered and left just after a rising edge.
    task automatic drive(input logic we, input logic [31:0] din, input logic re);
        logic exp_wr, exp_rd, pre_full, pre_empty;
        pre_full  = (m_count == 128);
        pre_empty = (m_count == 0);
        exp_wr    = we && !pre_full;
        exp_rd    = re && !pre_empty;
        i_we = we; i_din = din; i_re = re;
        @(negedge clk);
        check("ram_wen", o_ram_wen, exp_wr);
        check("ram_ren", o_ram_ren, exp_rd);
        if (exp_wr) begin
            check("ram_waddr", o_ram_waddr, m_wptr);
            check("ram_wdata", o_ram_wdata, din);
        end
        if (exp_rd) check("ram_raddr", o_ram_raddr, m_rptr);
        @(posedge clk); #1;
        if (exp_rd) begin
            exp_q.push_back(data_q.pop_front());
            m_rptr = m_rptr + 7'd1;
        end
        if (exp_wr) begin
            data_q.push_back(din);
            m_wptr = m_wptr + 7'd1;
        end
        m_count = m_count + int'(exp_wr) - int'(exp_rd);
        check("count",     o_count,     m_count);
        check("full",      o_full,      m_count == 128);
        check("empty",     o_empty,     m_count == 0);
        check("afull",     o_afull,     m_count >= 120);
        check("aempty",    o_aempty,    m_count <= 8);
        check("dvalid",    o_dvalid,    exp_rd);
        check("overflow",  o_overflow,  we && pre_full);
        check("underflow", o_underflow, re && pre_empty);
    endtask

    // Scoreboard monitor: each DVALID beat must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (o_dvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL dout_unexpected: got %0h expected no beat at %0t", o_dout, $time);
                end else begin
                    check("dout", o_dout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        i_reset = 1'b1; i_we = 1'b0; i_re = 1'b0; i_din = 32'd0;
        #2;
        check("rst_count",  o_count,  0);
        check("rst_empty",  o_empty,  1);
        check("rst_full",   o_full,   0);
        check("rst_aempty", o_aempty, 1);
        check("rst_afull",  o_afull,  0);
        check("rst_dvalid", o_dvalid, 0);
        check("rst_ovf",    o_overflow, 0);
        check("rst_udf",    o_underflow, 0);
        @(posedge clk); #1;
        i_reset = 1'b0;

        // 1: push 0x11..0x15, pop five
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h11 + 32'(i), 1'b0);
        check("t1_count5", o_count, 5);
        check("t1_notempty", o_empty, 0);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'd0, 1'b1);
        drive(1'b0, 32'd0, 1'b0);
        check("t1_empty", o_empty, 1);

        // 2: fill to 128, then an overflowing push
        for (int i = 0; i < 128; i++) drive(1'b1, 32'h1000 + 32'(i), 1'b0);
        check("t2_full", o_full, 1);
        check("t2_afull", o_afull, 1);
        drive(1'b1, 32'hDEAD, 1'b0);
        check("t2_count128", o_count, 128);

        // 3: drain, underflow, then push+pop while empty
        for (int i = 0; i < 128; i++) drive(1'b0, 32'd0, 1'b1);
        drive(1'b0, 32'd0, 1'b1);
        pat = 32'h2000;
        drive(1'b1, pat, 1'b1);
        pat = pat + 32'd1;
        check("t3_count1", o_count, 1);

        // 4: fill to 127 and stream 300 cycles
        for (int i = 0; i < 126; i++) begin
            drive(1'b1, pat, 1'b0);
            pat = pat + 32'd1;
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, pat, 1'b1);
            pat = pat + 32'd1;
        end
        check("t4_count127", o_count, 127);

        // 5: full with simultaneous push and pop
        drive(1'b1, pat, 1'b0);
        pat = pat + 32'd1;
        drive(1'b1, pat, 1'b1);
        check("t5_count127", o_count, 127);

        // 6: reset while streaming at count 40 with a pop in flight
        for (int i = 0; i < 87; i++) drive(1'b0, 32'd0, 1'b1);
        drive(1'b1, pat, 1'b1);
        check("t6_count40", o_count, 40);
        i_reset = 1'b1;
        #1;
        check("t6_count0",  o_count,   0);
        check("t6_empty",   o_empty,   1);
        check("t6_dvalid",  o_dvalid,  0);
        check("t6_ram_wen", o_ram_wen, 0);
        check("t6_ram_ren", o_ram_ren, 0);
        exp_q.delete();
        data_q.delete();
        m_count = 0; m_wptr = 7'd0; m_rptr = 7'd0;
        @(posedge clk); #1;
        i_reset = 1'b0; i_we = 1'b0; i_re = 1'b0;
        drive(1'b1, 32'hABCD, 1'b0);
        check("t6_waddr_after", m_wptr, 7'd1);
        drive(1'b0, 32'd0, 1'b1);
        drive(1'b0, 32'd0, 1'b0);
        drive(1'b0, 32'd0, 1'b0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsram_fifo_ctrl.md
Name: lsram_fifo_ctrl

Overview:
Single-clock FIFO controller that sequences the LSRAM two-port RAM wrapper.
- Generates write/read addresses and enables for the RAM.
- Tracks occupancy and flags full/empty/almost-full/almost-empty, overflow and underflow.
- Returns read data with a fixed 1-cycle latency and a valid strobe.
- Sits between the digitizer sample stream (write side) and downstream readout logic (read side). The RAM is instantiated externally and connected through the RAM_* ports.

Parameters:
WIDTH, 32, data width (write and read).
ADDR_W, 7, RAM address width; DEPTH = 2**ADDR_W (128).
AFULL_TH, 120, AFULL asserted when count >= AFULL_TH.
AEMPTY_TH, 8, AEMPTY asserted when count <= AEMPTY_TH.

Ports:
CLOCK  in  1  single clock; all logic on rising edge.
RESET  in  1  asynchronous, active-high reset.
WE  in  1  push request.
DIN  in  WIDTH  push data.
RE  in  1  pop request.
DOUT  out  WIDTH  pop data; RAM_RDATA passed through combinationally.
DVALID  out  1  DOUT valid, 1 cycle after an accepted pop.
FULL  out  1  count == DEPTH.
EMPTY  out  1  count == 0.
AFULL  out  1  almost full.
AEMPTY  out  1  almost empty.
COUNT  out  ADDR_W+1  current occupancy, 0..DEPTH.
OVERFLOW  out  1  one-cycle pulse: push rejected.
UNDERFLOW  out  1  one-cycle pulse: pop rejected.
RAM_WADDR  out  ADDR_W  RAM write address.
RAM_WEN  out  1  RAM write enable.
RAM_WDATA  out  WIDTH  RAM write data.
RAM_RADDR  out  ADDR_W  RAM read address.
RAM_REN  out  1  RAM read enable.
RAM_RDATA  in  WIDTH  RAM read data; valid 1 cycle after RAM_REN.

Behaviour:
- Reset (async assert, sync-safe deassert): wptr=0, rptr=0, COUNT=0, EMPTY=1, FULL=0, AEMPTY=1, AFULL=0, DVALID=0, OVERFLOW=0, UNDERFLOW=0.
- RAM contents are not cleared on reset. After reset they are unreachable because the pointers restart at 0.
- Internal state: wptr and rptr (ADDR_W bits, natural wrap DEPTH-1 -> 0), count register.
- Accept rules use the registered flags only:
  - wr_ok = WE & !FULL.
  - rd_ok = RE & !EMPTY.
- Simultaneous push and pop follow the same rules:
  - When FULL, a push is rejected even with a concurrent pop.
  - When EMPTY, a pop is rejected even with a concurrent push.
- Write path (combinational to RAM):
  - RAM_WEN = wr_ok, RAM_WADDR = wptr, RAM_WDATA = DIN.
  - wptr increments on wr_ok.
- Read path:
  - RAM_REN = rd_ok, RAM_RADDR = rptr.
  - rptr increments on rd_ok.
  - DVALID <= rd_ok (registered), so DVALID is high exactly 1 cycle after an accepted pop.
  - DOUT = RAM_RDATA; it is meaningful only when DVALID=1.
- Read-after-write hazard cannot occur:
  - A pop only reads entries written in an earlier cycle, because count>0 means the entry is already committed.
  - RAM_WADDR never equals RAM_RADDR with both enables high unless count==DEPTH, and in that case the write is blocked.
- Count update:
  - wr_ok & !rd_ok: +1.
  - rd_ok & !wr_ok: -1.
  - both or neither: unchanged.
- Flags are registered, computed from the next count, and take effect the cycle after the event:
  - FULL = (next==DEPTH).
  - EMPTY = (next==0).
  - AFULL = (next>=AFULL_TH).
  - AEMPTY = (next<=AEMPTY_TH).
- Error pulses, registered, 1 cycle wide:
  - OVERFLOW <= WE & FULL.
  - UNDERFLOW <= RE & EMPTY.
  - Pointers and count are unaffected by rejected requests.
- Wrap-around: pointers roll over silently. Full and empty are distinguished solely by count.
- Reset asserted mid-operation: all state returns to reset values immediately (async).
  - An in-flight DVALID is cleared.
  - The RAM access issued in the same cycle is discarded, because enables drop to 0 combinationally.

Test Plan:
1. Reset, then push 5 words 0x11..0x15, then pop 5 -> RAM_WADDR 0..4, COUNT 5, EMPTY=0. Pops give DOUT 0x11..0x15, each with DVALID 1 cycle after RE. Final EMPTY=1, COUNT=0.
2. Push 128 words -> FULL=1 and AFULL=1 at COUNT 128 (AFULL already at 120). 129th push -> OVERFLOW pulse, RAM_WEN=0, COUNT stays 128.
3. Pop when EMPTY -> UNDERFLOW pulse, RAM_REN=0, DVALID=0. Push+pop in the same cycle while EMPTY -> write accepted, pop rejected, COUNT=1.
4. Fill to 127, then run continuous push+pop for 300 cycles -> COUNT constant at 127, pointers wrap past 127->0, data order preserved (incrementing pattern checked).
5. FULL with simultaneous WE+RE -> pop accepted, push rejected with OVERFLOW, COUNT 127 next cycle.
6. Assert RESET while streaming (COUNT 40, pop in flight) -> the same cycle shows COUNT 0, EMPTY 1, DVALID 0, RAM_WEN/RAM_REN 0. After release, the first push goes to RAM_WADDR 0.
